// File: rtl/ttl_keypad_pkg.sv
// Shared types and constants for the 74C922-style keypad encoder.
// Holds the FSM state encoding and the row priority helper.
package ttl_keypad_pkg;

  localparam int KEY_CODE_WIDTH   = 4;
  localparam int SCAN_INDEX_WIDTH = 2;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  // Lowest-numbered active-low row wins when several rows are pulled down.
  function automatic logic [1:0] first_low_row(input logic [3:0] row_bar);
    first_low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_bar[i]) first_low_row = 2'(i);
    end
  endfunction

endpackage

// File: rtl/ttl_74c922_if.sv
// Keypad-side and CPU-side control signals of the encoder.
// The 3-state data bus stays a plain port on the encoder itself.
interface ttl_74c922_if #(
  parameter int WIDTH_ROWS = 4,
  parameter int WIDTH_COLS = 4
);

  logic [WIDTH_ROWS-1:0] Row_bar;
  logic                  Output_Enable_bar;
  logic [WIDTH_COLS-1:0] Column_bar;
  logic                  Data_Available;

  modport master (
    output Row_bar, Output_Enable_bar,
    input  Column_bar, Data_Available
  );

  modport slave (
    input  Row_bar, Output_Enable_bar,
    output Column_bar, Data_Available
  );

endinterface

// File: rtl/ttl_debounce_counter.sv
// Counts consecutive clocks at the wanted level; done marks the final stable clock.
// Shared by the press (DEBOUNCE) and release (RELEASE) phases.
module ttl_debounce_counter #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic level_ok,
  output logic done
);

  localparam int               COUNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [COUNT_WIDTH-1:0] LAST  = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [COUNT_WIDTH-1:0] count;

  assign done = enable && level_ok && (count == LAST);

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && level_ok) begin
      count <= done ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/ttl_74c922.sv
// 16-key keypad encoder: column scan, press/release debounce, latched code on a 3-state bus.
// Column drive and all outputs come from registers only; Row_bar never reaches an output combinationally.
module ttl_74c922
  import ttl_keypad_pkg::*;
#(
  parameter int WIDTH_ROWS      = 4,
  parameter int WIDTH_COLS      = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DELAY_RISE      = 0,
  parameter int DELAY_FALL      = 0
) (
  input  logic                      Clk,
  input  logic                      Clear_bar,
  ttl_74c922_if.slave               kp,
  output wire [KEY_CODE_WIDTH-1:0]  D
);

  state_t                      state;
  logic [SCAN_INDEX_WIDTH-1:0] scan_idx;
  logic [1:0]                  row_idx;
  logic [KEY_CODE_WIDTH-1:0]   d_q;
  logic [KEY_CODE_WIDTH-1:0]   d_dly;
  logic                        avail_q;
  logic [WIDTH_ROWS-1:0]       rows;
  logic [WIDTH_COLS-1:0]       column_q;
  logic                        row_hit;
  logic                        cap_low;
  logic                        cnt_en;
  logic                        cnt_level;
  logic                        cnt_done;

  assign rows    = kp.Row_bar;
  assign row_hit = ~&rows;
  assign cap_low = ~rows[row_idx];

  // Press debounce wants the captured row low; release debounce wants it high.
  assign cnt_en    = (state == DEBOUNCE) || (state == RELEASE);
  assign cnt_level = (state == DEBOUNCE) ? cap_low : ~cap_low;

  ttl_debounce_counter #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (Clk),
    .rst_n    (Clear_bar),
    .clear    (~(cnt_en && cnt_level)),
    .enable   (cnt_en),
    .level_ok (cnt_level),
    .done     (cnt_done)
  );

  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      state    <= SCAN;
      scan_idx <= '0;
      row_idx  <= '0;
      d_q      <= '0;
      avail_q  <= 1'b0;
    end else begin
      // NOTE: every state path either assigns or holds, and the default arm recovers illegal codes.
      unique case (state)
        SCAN: begin
          if (row_hit) begin
            row_idx <= first_low_row(rows);
            state   <= DEBOUNCE;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!cap_low) begin
            scan_idx <= scan_idx + 1'b1;
            state    <= SCAN;
          end else if (cnt_done) begin
            d_q     <= {row_idx, scan_idx};
            avail_q <= 1'b1;
            state   <= HELD;
          end
        end
        HELD: begin
          if (!cap_low) state <= RELEASE;
        end
        RELEASE: begin
          if (cap_low) begin
            state <= HELD;
          end else if (cnt_done) begin
            avail_q  <= 1'b0;
            scan_idx <= scan_idx + 1'b1;
            state    <= SCAN;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  assign column_q = ~(WIDTH_COLS'(1) << scan_idx);

  assign #(DELAY_RISE, DELAY_FALL) kp.Column_bar     = column_q;
  assign #(DELAY_RISE, DELAY_FALL) kp.Data_Available = avail_q;
  assign #(DELAY_RISE, DELAY_FALL) d_dly             = d_q;

  assign D = kp.Output_Enable_bar ? {KEY_CODE_WIDTH{1'bz}} : d_dly;

endmodule

// File: tb/tb_ttl_74c922.sv
// Directed and randomized bench for the keypad encoder against a key-level reference model.
// The model tracks which key is locked and how many consecutive stable samples it has seen.
module tb_ttl_74c922;

  localparam int N = 4;

  logic       Clk = 1'b0;
  logic       Clear_bar;
  wire  [3:0] d_bus;
  int         checks = 0;
  int         errors = 0;

  int         m_col;
  int         m_lock;
  int         m_run;
  bit         m_avail;
  logic [3:0] m_d;

  ttl_74c922_if kp ();

  ttl_74c922 #(
    .DEBOUNCE_CYCLES (N)
  ) dut (
    .Clk       (Clk),
    .Clear_bar (Clear_bar),
    .kp        (kp.slave),
    .D         (d_bus)
  );

  always #5 Clk = ~Clk;

  function automatic void model_reset();
    m_col   = 0;
    m_lock  = -1;
    m_run   = 0;
    m_avail = 1'b0;
    m_d     = 4'h0;
  endfunction

  // Key-level view: scanning, confirming a press (N low samples after detect),
  // or holding a latched key (N+1 consecutive high samples to let go).
  function automatic void model_step(input logic [3:0] rows);
    if (m_lock < 0) begin
      if (rows != 4'hF) begin
        for (int r = 3; r >= 0; r--) if (!rows[r]) m_lock = r;
        m_run = 0;
      end else begin
        m_col = (m_col + 1) % 4;
      end
    end else if (!m_avail) begin
      if (rows[m_lock]) begin
        m_lock = -1;
        m_col  = (m_col + 1) % 4;
      end else begin
        m_run++;
        if (m_run == N) begin
          m_avail = 1'b1;
          m_d     = 4'(m_lock * 4 + m_col);
          m_run   = 0;
        end
      end
    end else begin
      if (!rows[m_lock]) begin
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == N + 1) begin
          m_avail = 1'b0;
          m_lock  = -1;
          m_run   = 0;
          m_col   = (m_col + 1) % 4;
        end
      end
    end
  endfunction

  // Switch-matrix view: a pressed key pulls its row low only while its column is driven.
  function automatic logic [3:0] rows_for(input int key);
    rows_for = 4'hF;
    if (m_col == key % 4) rows_for[key / 4] = 1'b0;
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0] col_exp;
    col_exp = ~(4'b0001 << m_col);
    check({tag, ":col"}, kp.Column_bar, col_exp);
    check({tag, ":da"}, {3'b000, kp.Data_Available}, {3'b000, m_avail});
    if (!kp.Output_Enable_bar) check({tag, ":d"}, d_bus, m_d);
  endtask

  task automatic tick(input logic [3:0] rows, input string tag);
    kp.Row_bar = rows;
    @(posedge Clk);
    model_step(rows);
    @(negedge Clk);
    check_outputs(tag);
  endtask

  initial begin
    Clear_bar            = 1'b0;
    kp.Row_bar           = 4'hF;
    kp.Output_Enable_bar = 1'b0;
    model_reset();

    // Reset state, then free-running scan.
    @(negedge Clk);
    check("reset_col", kp.Column_bar, 4'b1110);
    check("reset_d", d_bus, 4'b0000);
    check("reset_da", {3'b000, kp.Data_Available}, 4'b0000);
    Clear_bar = 1'b1;
    for (int i = 0; i < 4; i++) tick(4'hF, "scan");
    check("scan_wrap", kp.Column_bar, 4'b1110);

    // Key at row 2, column 1: freeze, debounce, latch 1001.
    tick(4'hF, "to_col1");
    for (int i = 0; i < N + 1; i++) tick(4'b1011, "press_r2c1");
    check("press_d", d_bus, 4'b1001);
    kp.Output_Enable_bar = 1'b1;
    #1;
    checks++;
    assert (d_bus === 4'bzzzz) else begin
      errors++;
      $error("FAIL oe_hiz: observed %b expected zzzz", d_bus);
    end
    check("oe_da", {3'b000, kp.Data_Available}, 4'b0001);
    kp.Output_Enable_bar = 1'b0;

    // Release with a bounce back low at count 2, then a clean release.
    for (int i = 0; i < 3; i++) tick(4'hF, "rel_bounce");
    tick(4'b1011, "rel_relow");
    check("rel_relow_da", {3'b000, kp.Data_Available}, 4'b0001);
    for (int i = 0; i < N + 1; i++) tick(4'hF, "rel_clean");
    check("rel_col", kp.Column_bar, 4'b1011);
    check("rel_d_kept", d_bus, 4'b1001);

    // Short press bounce at column 3: no latch, scan resumes at column 0.
    tick(4'hF, "to_col3");
    tick(4'b1101, "bounce_lo");
    tick(4'b1101, "bounce_lo");
    tick(4'hF, "bounce_hi");
    check("bounce_col", kp.Column_bar, 4'b1110);

    // Two rows low in column 0: lowest row wins; other keys locked out while held.
    for (int i = 0; i < N + 1; i++) tick(4'b0101, "prio");
    check("prio_d", d_bus, 4'b0100);
    for (int i = 0; i < 3; i++) tick(4'b0100, "lockout");
    check("lockout_d", d_bus, 4'b0100);

    // Asynchronous clear while held.
    #2;
    Clear_bar = 1'b0;
    #1;
    model_reset();
    check("clr_col", kp.Column_bar, 4'b1110);
    check("clr_d", d_bus, 4'b0000);
    check("clr_da", {3'b000, kp.Data_Available}, 4'b0000);
    kp.Row_bar = 4'hF;
    @(negedge Clk);
    Clear_bar = 1'b1;

    // Randomized key presses with random hold and gap lengths.
    for (int k = 0; k < 40; k++) begin
      int key;
      int hold;
      int gap;
      key  = $urandom_range(15, 0);
      hold = $urandom_range(12, 1);
      gap  = $urandom_range(10, 1);
      for (int i = 0; i < hold; i++) begin
        kp.Output_Enable_bar = ($urandom_range(3, 0) == 0);
        tick(rows_for(key), "rnd_press");
      end
      for (int i = 0; i < gap; i++) tick(4'hF, "rnd_gap");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
